// File: rtl/store_narrow_if.sv
// Store-narrowing handshake bundle: core request side and memory write side.
// master = requester/memory environment, slave = store_narrow.
interface store_narrow_if;
  logic        InValid;
  logic        InReady;
  logic [31:0] InData;
  logic [31:0] InAddr;
  logic [1:0]  InSize;
  logic        MemValid;
  logic        MemReady;
  logic [31:0] MemAddr;
  logic [31:0] MemWData;
  logic [3:0]  MemBE;
  logic        AlignErr;
  logic        TruncErr;

  modport master (
    output InValid,
    output InData,
    output InAddr,
    output InSize,
    output MemReady,
    input  InReady,
    input  MemValid,
    input  MemAddr,
    input  MemWData,
    input  MemBE,
    input  AlignErr,
    input  TruncErr
  );

  modport slave (
    input  InValid,
    input  InData,
    input  InAddr,
    input  InSize,
    input  MemReady,
    output InReady,
    output MemValid,
    output MemAddr,
    output MemWData,
    output MemBE,
    output AlignErr,
    output TruncErr
  );
endinterface

// File: rtl/store_narrow.sv
// Store narrowing: lane-aligns byte/half/word stores into a 2-entry FIFO.
// Optional macro STORE_TRUNC_CHECK_EN adds the TruncErr significance check.
module store_narrow (
  input logic           CLK,
  input logic           Reset,
  store_narrow_if.slave bus
);

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } ent_t;

  ent_t       fifo [2];
  logic [1:0] count;
  logic       wptr;
  logic       rptr;
  logic       align_q;

  ent_t       lane;
  logic       legal;
  logic       accept;
  logic       enq;
  logic       deq;

  logic [31:0] d;
  logic [31:0] a;

  assign d = bus.InData;
  assign a = bus.InAddr;

  // Flow control only depends on registered occupancy.
  assign bus.InReady  = (count < 2'd2);
  assign bus.MemValid = (count != 2'd0);

  assign accept = bus.InValid & bus.InReady;
  assign enq    = accept & legal;
  assign deq    = bus.MemValid & bus.MemReady;

  // Size/alignment decode and lane replication of the incoming store.
  always_comb begin
    lane       = '0;
    legal      = 1'b0;
    lane.addr  = {a[31:2], 2'b00};
    unique case (bus.InSize)
      2'b00: begin
        legal      = 1'b1;
        lane.wdata = {4{d[7:0]}};
        lane.be    = 4'b0001 << a[1:0];
      end
      2'b01: begin
        legal      = ~a[0];
        lane.wdata = {2{d[15:0]}};
        lane.be    = a[1] ? 4'b1100 : 4'b0011;
      end
      2'b10: begin
        legal      = (a[1:0] == 2'b00);
        lane.wdata = d;
        lane.be    = 4'b1111;
      end
      default: begin
        legal      = 1'b0;
      end
    endcase
  end

  // FIFO storage, pointers, occupancy and the alignment error pulse.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      count   <= 2'd0;
      wptr    <= 1'b0;
      rptr    <= 1'b0;
      align_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        fifo[i] <= '0;
      end
    end else begin
      align_q <= accept & ~legal;
      if (enq) begin
        fifo[wptr] <= lane;
        wptr       <= ~wptr;
      end
      if (deq) begin
        rptr <= ~rptr;
      end
      unique case ({enq, deq})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign bus.MemAddr  = fifo[rptr].addr;
  assign bus.MemWData = fifo[rptr].wdata;
  assign bus.MemBE    = fifo[rptr].be;
  assign bus.AlignErr = align_q;

`ifdef STORE_TRUNC_CHECK_EN
  logic byte_bad;
  logic half_bad;
  logic trunc_d;
  logic trunc_q;

  // Upper bits must be a zero- or sign-extension of the stored field.
  always_comb begin
    byte_bad = ~((d[31:8] == 24'h0) ||
                 (d[31:8] == {24{d[7]}}));
    half_bad = ~((d[31:16] == 16'h0) ||
                 (d[31:16] == {16{d[15]}}));
    trunc_d  = enq &
               (((bus.InSize == 2'b00) & byte_bad) |
                ((bus.InSize == 2'b01) & half_bad));
  end

  // One-cycle pulse after an enqueued lossy narrowing store.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      trunc_q <= 1'b0;
    end else begin
      trunc_q <= trunc_d;
    end
  end

  assign bus.TruncErr = trunc_q;
`else
  assign bus.TruncErr = 1'b0;
`endif

endmodule

// File: tb/tb_store_narrow.sv
// Bench for store_narrow: vector table, scoreboard of memory writes,
// plus back-pressure, accept/retire overlap and reset-flush sequences.
module tb_store_narrow;

  logic clk = 1'b0;
  logic rst;

  store_narrow_if bus ();

  store_narrow dut (
    .CLK   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

`ifdef STORE_TRUNC_CHECK_EN
  localparam bit TRUNC_EN = 1'b1;
`else
  localparam bit TRUNC_EN = 1'b0;
`endif

  typedef struct {
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
    bit          legal;
    logic [3:0]  be;
    logic [31:0] wdata;
    bit          trunc;
  } vec_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } wr_t;

  wr_t  exp_q [$];
  wr_t  mon_e;
  int   checks = 0;
  int   errors = 0;
  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be);
    wr_t e;
    e.addr  = addr & 32'hFFFF_FFFC;
    e.wdata = wdata;
    e.be    = be;
    exp_q.push_back(e);
  endtask

  task automatic put(input logic [1:0] size, input logic [31:0] addr,
                     input logic [31:0] data);
    bus.InSize  = size;
    bus.InAddr  = addr;
    bus.InData  = data;
    bus.InValid = 1'b1;
  endtask

  // Present a request until accepted (bounded); returns at posedge+1 after.
  task automatic send(input vec_t v);
    bit ok;
    ok = 1'b0;
    put(v.size, v.addr, v.data);
    for (int i = 0; i < 20 && !ok; i++) begin
      if (bus.InReady === 1'b1) begin
        ok = 1'b1;
        if (v.legal) push_exp(v.addr, v.wdata, v.be);
      end
      @(posedge clk);
      #1;
    end
    bus.InValid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no accept want accept addr %h", v.addr);
    end
  endtask

  // Scoreboard: every write the memory takes must match the queue head.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.MemValid === 1'b1 && bus.MemReady === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %h want none", bus.MemAddr);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", bus.MemAddr, mon_e.addr);
        chk("wr_wdata", bus.MemWData, mon_e.wdata);
        chk("wr_be", {28'h0, bus.MemBE}, {28'h0, mon_e.be});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{2'b00, 32'h103, 32'h0000_00A5, 1, 4'b1000, 32'hA5A5_A5A5, 0};
    tbl[1]  = '{2'b00, 32'h100, 32'h0000_1280, 1, 4'b0001, 32'h8080_8080, 1};
    tbl[2]  = '{2'b00, 32'h101, 32'hFFFF_FF80, 1, 4'b0010, 32'h8080_8080, 0};
    tbl[3]  = '{2'b01, 32'h200, 32'h0000_1234, 1, 4'b0011, 32'h1234_1234, 0};
    tbl[4]  = '{2'b01, 32'h202, 32'hABCD_8001, 1, 4'b1100, 32'h8001_8001, 1};
    tbl[5]  = '{2'b01, 32'h201, 32'h0000_1234, 0, 4'b0000, 32'h0, 0};
    tbl[6]  = '{2'b10, 32'h300, 32'hDEAD_BEEF, 1, 4'b1111, 32'hDEAD_BEEF, 0};
    tbl[7]  = '{2'b10, 32'h302, 32'hDEAD_BEEF, 0, 4'b0000, 32'h0, 0};
    tbl[8]  = '{2'b11, 32'h400, 32'h1111_2222, 0, 4'b0000, 32'h0, 0};
    tbl[9]  = '{2'b00, 32'h102, 32'hFFFF_FF7F, 1, 4'b0100, 32'h7F7F_7F7F, 1};
    tbl[10] = '{2'b01, 32'h002, 32'hFFFF_8000, 1, 4'b1100, 32'h8000_8000, 0};

    // Reset with a request presented: it must not be taken.
    rst          = 1'b1;
    bus.MemReady = 1'b0;
    put(2'b00, 32'h800, 32'h55);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_memvalid", {31'h0, bus.MemValid}, 32'd0);
    chk("rst_inready", {31'h0, bus.InReady}, 32'd1);
    chk("rst_alignerr", {31'h0, bus.AlignErr}, 32'd0);
    chk("rst_truncerr", {31'h0, bus.TruncErr}, 32'd0);
    chk("rst_memaddr", bus.MemAddr, 32'h0);
    chk("rst_memwdata", bus.MemWData, 32'h0);
    chk("rst_membe", {28'h0, bus.MemBE}, 32'h0);
    rst         = 1'b0;
    bus.InValid = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_req_dropped", {31'h0, bus.MemValid}, 32'd0);

    // Single stores with the memory always ready.
    bus.MemReady = 1'b1;
    for (int i = 0; i < 11; i++) begin
      send(tbl[i]);
      chk($sformatf("v%0d_align", i), {31'h0, bus.AlignErr},
          {31'h0, ~tbl[i].legal});
      chk($sformatf("v%0d_trunc", i), {31'h0, bus.TruncErr},
          {31'h0, TRUNC_EN & tbl[i].trunc});
      chk($sformatf("v%0d_valid", i), {31'h0, bus.MemValid},
          {31'h0, tbl[i].legal});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_align_off", i), {31'h0, bus.AlignErr}, 32'd0);
      chk($sformatf("v%0d_trunc_off", i), {31'h0, bus.TruncErr}, 32'd0);
      chk($sformatf("v%0d_valid_off", i), {31'h0, bus.MemValid}, 32'd0);
    end

    // Back-pressure: two words fill the FIFO, the third waits.
    bus.MemReady = 1'b0;
    put(2'b10, 32'h500, 32'hAAAA_0001);
    chk("bp_ready_a", {31'h0, bus.InReady}, 32'd1);
    push_exp(32'h500, 32'hAAAA_0001, 4'b1111);
    @(posedge clk);
    #1;
    put(2'b10, 32'h504, 32'hBBBB_0002);
    chk("bp_ready_b", {31'h0, bus.InReady}, 32'd1);
    push_exp(32'h504, 32'hBBBB_0002, 4'b1111);
    @(posedge clk);
    #1;
    put(2'b10, 32'h508, 32'hCCCC_0003);
    for (int i = 0; i < 3; i++) begin
      chk("bp_full", {31'h0, bus.InReady}, 32'd0);
      chk("bp_hold_addr", bus.MemAddr, 32'h500);
      chk("bp_hold_data", bus.MemWData, 32'hAAAA_0001);
      chk("bp_valid", {31'h0, bus.MemValid}, 32'd1);
      @(posedge clk);
      #1;
    end
    bus.MemReady = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_ready_c", {31'h0, bus.InReady}, 32'd1);
    push_exp(32'h508, 32'hCCCC_0003, 4'b1111);
    @(posedge clk);
    #1;
    bus.InValid = 1'b0;
    for (int i = 0; i < 10 && bus.MemValid === 1'b1; i++) begin
      @(posedge clk);
      #1;
    end
    chk("bp_drained_valid", {31'h0, bus.MemValid}, 32'd0);
    chk("bp_drained_q", exp_q.size(), 32'd0);

    // Accept and retire in the same cycle at count=1.
    bus.MemReady = 1'b0;
    put(2'b10, 32'h600, 32'h1111_1111);
    push_exp(32'h600, 32'h1111_1111, 4'b1111);
    @(posedge clk);
    #1;
    put(2'b10, 32'h604, 32'h2222_2222);
    bus.MemReady = 1'b1;
    chk("ov_valid", {31'h0, bus.MemValid}, 32'd1);
    chk("ov_ready", {31'h0, bus.InReady}, 32'd1);
    push_exp(32'h604, 32'h2222_2222, 4'b1111);
    @(posedge clk);
    #1;
    bus.InValid = 1'b0;
    chk("ov_valid_next", {31'h0, bus.MemValid}, 32'd1);
    chk("ov_ready_next", {31'h0, bus.InReady}, 32'd1);
    chk("ov_addr_next", bus.MemAddr, 32'h604);
    chk("ov_data_next", bus.MemWData, 32'h2222_2222);
    @(posedge clk);
    #1;
    chk("ov_empty", {31'h0, bus.MemValid}, 32'd0);

    // Reset flushes two buffered entries held by MemReady low.
    bus.MemReady = 1'b0;
    put(2'b10, 32'h700, 32'h7777_0000);
    push_exp(32'h700, 32'h7777_0000, 4'b1111);
    @(posedge clk);
    #1;
    put(2'b10, 32'h704, 32'h7777_0004);
    push_exp(32'h704, 32'h7777_0004, 4'b1111);
    @(posedge clk);
    #1;
    bus.InValid = 1'b0;
    chk("fl_full", {31'h0, bus.InReady}, 32'd0);
    chk("fl_valid", {31'h0, bus.MemValid}, 32'd1);
    exp_q.delete();
    rst = 1'b1;
    put(2'b10, 32'h708, 32'h7777_0008);
    @(posedge clk);
    #1;
    chk("fl_memvalid", {31'h0, bus.MemValid}, 32'd0);
    chk("fl_inready", {31'h0, bus.InReady}, 32'd1);
    chk("fl_membe", {28'h0, bus.MemBE}, 32'd0);
    chk("fl_memaddr", bus.MemAddr, 32'h0);
    rst          = 1'b0;
    bus.InValid  = 1'b0;
    bus.MemReady = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("fl_no_write", {31'h0, bus.MemValid}, 32'd0);
    end

    chk("final_queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/store_narrow.md
STORE_NARROW -- requirements
Module: store_narrow

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports: CLK input 1, rising-edge clock; Reset input 1, synchronous, active-high.
REQ-002 InValid  input  1  core has a store request.
REQ-003 InReady  output 1  block can accept a request this cycle.
REQ-004 InData   input  32 register value to store.
REQ-005 InAddr   input  32 byte address.
REQ-006 InSize   input  2  access size: 00 byte, 01 halfword, 10 word, 11 illegal.
REQ-007 MemValid output 1  a memory write is presented.
REQ-008 MemReady input  1  memory accepts the write this cycle.
REQ-009 MemAddr  output 32 word address, InAddr with bits [1:0] forced to 0.
REQ-010 MemWData output 32 lane-aligned write data.
REQ-011 MemBE    output 4  byte enables; bit i enables byte lane i (bits 8i+7:8i).
REQ-012 AlignErr output 1  one-cycle pulse: a request was rejected as misaligned or illegal size.
REQ-013 TruncErr output 1  one-cycle pulse: narrowing discarded significant bits (see Configuration).

Function
REQ-014 Requests SHALL be buffered in a 2-entry FIFO with an occupancy count of 0..2.
REQ-015 InReady SHALL equal (count < 2), with no combinational path from MemReady.
REQ-016 A request SHALL be accepted when InValid && InReady are both high at a CLK edge.
REQ-017 An accepted request with InSize=11, halfword with InAddr[0]=1, or word with InAddr[1:0]!=00 SHALL NOT be enqueued, and AlignErr SHALL be 1 in the following cycle only.
REQ-018 Byte: MemWData = {4{InData[7:0]}}, MemBE = 4'b0001 << InAddr[1:0].
REQ-019 Halfword: MemWData = {2{InData[15:0]}}, MemBE = 0011 if InAddr[1]=0, else 1100.
REQ-020 Word: MemWData = InData, MemBE = 1111.
REQ-021 Lane mapping SHALL be computed at enqueue and stored; outputs SHALL come from registered FIFO head state.
REQ-022 MemValid SHALL equal (count != 0); MemAddr, MemWData and MemBE SHALL reflect the head entry and hold stable while MemValid && !MemReady.
REQ-023 A request accepted at edge N into an empty FIFO SHALL appear with MemValid=1 in cycle N+1 (1-cycle latency).
REQ-024 The head SHALL retire when MemValid && MemReady are both high at an edge.
REQ-025 Simultaneous enqueue and retire at count=1 SHALL leave count=1 and present the new entry next cycle.
REQ-026 Entries SHALL retire in acceptance order; pointers wrap modulo 2.
REQ-027 MemReady while MemValid=0 SHALL be ignored.

Reset
REQ-028 With Reset high at a CLK edge: count=0, pointers=0, MemValid=0, InReady=1 after the edge, AlignErr=0, TruncErr=0; MemAddr, MemWData and MemBE = 0.
REQ-029 Reset SHALL discard buffered entries, even one presented with MemReady low; a request presented in the reset cycle SHALL NOT be accepted.

Configuration
REQ-030 With macro STORE_TRUNC_CHECK_EN defined, TruncErr SHALL pulse in the cycle after an enqueued byte store whose InData[31:8] is neither all-0 nor all equal to InData[7], or a halfword store whose InData[31:16] is neither all-0 nor all equal to InData[15].
REQ-031 Such a store SHALL still be enqueued and written normally.
REQ-032 Without STORE_TRUNC_CHECK_EN, TruncErr SHALL be constant 0 and no check logic shall be built.

Verification
REQ-033 Byte store InData=0x000000A5, InAddr=0x103, MemReady=1 -> next cycle MemAddr=0x100, MemBE=1000, MemWData=0xA5A5A5A5, MemValid=1 for one cycle.
REQ-034 Halfword store InAddr=0x201 -> AlignErr=1 for one cycle, MemValid stays 0, count unchanged.
REQ-035 MemReady=0, three back-to-back word stores -> first two accepted, InReady=0 on the third; raise MemReady -> writes emitted in order, third accepted after the first retires.
REQ-036 count=1 plus simultaneous accept and retire -> count stays 1, new entry presented next cycle.
REQ-037 Byte store InData=0x00001280, with STORE_TRUNC_CHECK_EN -> TruncErr=1 and write performed. Byte store InData=0xFFFFFF80 -> TruncErr=0. Without the macro -> TruncErr=0 in both cases.
REQ-038 Two entries buffered with MemReady=0, then Reset -> MemValid=0, InReady=1, and no buffered write emitted afterwards.
